// File: rtl/addr_cal_pkg.sv
// Shared field layout, bus payload types and default widths for the sprite address calculator.
package addr_cal_pkg;

    localparam int unsigned CNT_W_DEFAULT  = 10;
    localparam int unsigned ADDR_W_DEFAULT = 16;

    // pattern_info layout
    localparam int unsigned DIM_W          = 16;
    localparam int unsigned PAT_W          = 80;
    localparam int unsigned PAT_APPEND_LSB = 64;
    localparam int unsigned PAT_RES_H_LSB  = 48;
    localparam int unsigned PAT_RES_V_LSB  = 32;
    localparam int unsigned PAT_ACT_H_LSB  = 16;
    localparam int unsigned PAT_ACT_V_LSB  = 0;

    // sprite_info layout
    localparam int unsigned SPR_W           = 32;
    localparam int unsigned SPR_VISIBLE_BIT = 31;
    localparam int unsigned SPR_HFLIP_BIT   = 30;
    localparam int unsigned POS_W           = 10;
    localparam int unsigned SPR_X_LSB       = 20;
    localparam int unsigned SPR_Y_LSB       = 10;
    localparam int unsigned SPR_RSVD_W      = 10;

    localparam int unsigned CALC_W = 32;

    typedef struct packed {
        logic [DIM_W-1:0] append;
        logic [DIM_W-1:0] res_h;
        logic [DIM_W-1:0] res_v;
        logic [DIM_W-1:0] act_h;
        logic [DIM_W-1:0] act_v;
    } pattern_info_t;

    typedef struct packed {
        logic                  visible;
        logic                  hflip;
        logic [POS_W-1:0]      x_pos;
        logic [POS_W-1:0]      y_pos;
        logic [SPR_RSVD_W-1:0] rsvd;
    } sprite_info_t;

    // True when the displayed size is exactly twice the stored size (pixel doubling).
    function automatic logic is_doubled(input logic [DIM_W-1:0] act, input logic [DIM_W-1:0] res);
        return {1'b0, act} == {res, 1'b0};
    endfunction

endpackage

// File: rtl/addr_cal_axis.sv
// One axis of the sprite hit test: offset from sprite origin, in-range flag and scaled source index.
module addr_cal_axis
    import addr_cal_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] pos,
    input  logic [DIM_W-1:0] act,
    input  logic [DIM_W-1:0] res,
    output logic [CNT_W:0]   offset_c,
    output logic             in_range_c,
    output logic [CNT_W:0]   index_c
);

    localparam int unsigned OFF_W = CNT_W + 1;
    localparam int unsigned CMP_W = (OFF_W > DIM_W) ? OFF_W : DIM_W;

    logic [CMP_W-1:0] offset_ext;
    logic [CMP_W-1:0] act_ext;
    logic             doubled;

    // Extra MSB makes count < pos land far beyond any sprite instead of wrapping into it.
    assign offset_c   = {1'b0, count} - {1'b0, pos};

    assign offset_ext = CMP_W'(offset_c);
    assign act_ext    = CMP_W'(act);
    assign in_range_c = offset_ext < act_ext;

    assign doubled    = is_doubled(act, res);
    assign index_c    = doubled ? (offset_c >> 1) : offset_c;

endmodule

// File: rtl/addr_cal.sv
// Sprite-memory address calculator with one-cycle registered output.
// Optional horizontal flip enabled by defining ADDR_CAL_HFLIP_EN.
module addr_cal
    import addr_cal_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PAT_W-1:0]  pattern_info,
    input  logic [SPR_W-1:0]  sprite_info,
    input  logic [CNT_W-1:0]  hcount,
    input  logic [CNT_W-1:0]  vcount,
    output logic [ADDR_W-1:0] addr_output,
    output logic              valid
);

    pattern_info_t pat;
    sprite_info_t  spr;

    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic [CNT_W:0]    dx;
    logic [CNT_W:0]    dy;
    logic [CNT_W:0]    sx;
    logic [CNT_W:0]    sy;
    logic              h_in;
    logic              v_in;
    logic              hit_c;
    logic [CALC_W-1:0] column_c;
    logic [CALC_W-1:0] addr_sum_c;
    logic [ADDR_W-1:0] addr_next_c;

    assign pat   = pattern_info_t'(pattern_info);
    assign spr   = sprite_info_t'(sprite_info);
    assign x_pos = CNT_W'(spr.x_pos);
    assign y_pos = CNT_W'(spr.y_pos);

    addr_cal_axis #(.CNT_W(CNT_W)) u_axis_h (
        .count      (hcount),
        .pos        (x_pos),
        .act        (pat.act_h),
        .res        (pat.res_h),
        .offset_c   (dx),
        .in_range_c (h_in),
        .index_c    (sx)
    );

    addr_cal_axis #(.CNT_W(CNT_W)) u_axis_v (
        .count      (vcount),
        .pos        (y_pos),
        .act        (pat.act_v),
        .res        (pat.res_v),
        .offset_c   (dy),
        .in_range_c (v_in),
        .index_c    (sy)
    );

    // Zero-sized sprites never hit: offset < 0 is impossible.
    assign hit_c = spr.visible & h_in & v_in;

`ifdef ADDR_CAL_HFLIP_EN
    always_comb begin
        column_c = CALC_W'(sx);
        if (spr.hflip) begin
            column_c = CALC_W'(pat.res_h) - CALC_W'(1) - CALC_W'(sx);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{spr.rsvd, dx, dy};
`else
    assign column_c = CALC_W'(sx);

    logic unused_bits;
    assign unused_bits = ^{spr.rsvd, spr.hflip, dx, dy};
`endif

    // Address arithmetic wraps at 32 bits before truncation to the output width.
    assign addr_sum_c  = CALC_W'(pat.append) + CALC_W'(sy) * CALC_W'(pat.res_h) + column_c;
    assign addr_next_c = hit_c ? ADDR_W'(addr_sum_c) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_output <= '0;
            valid       <= 1'b0;
        end else begin
            addr_output <= addr_next_c;
            valid       <= hit_c;
        end
    end

endmodule

// File: tb/tb_addr_cal.sv
// Self-checking bench for addr_cal: directed vector table, reset sequences and randomized model compare.
module tb_addr_cal;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 16;

`ifdef ADDR_CAL_HFLIP_EN
    localparam logic [ADDR_W-1:0] FLIP_ADDR = 16'd181;
    localparam bit                FLIP_ON   = 1'b1;
`else
    localparam logic [ADDR_W-1:0] FLIP_ADDR = 16'd138;
    localparam bit                FLIP_ON   = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic [79:0]       pattern_info;
    logic [31:0]       sprite_info;
    logic [CNT_W-1:0]  hcount;
    logic [CNT_W-1:0]  vcount;
    logic [ADDR_W-1:0] addr_output;
    logic              valid;

    int total;
    int bad;

    typedef struct {
        string             name;
        logic [79:0]       pat;
        logic [31:0]       spr;
        logic [CNT_W-1:0]  h;
        logic [CNT_W-1:0]  v;
        logic              exp_valid;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    addr_cal #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mk_pat(input int app, input int rh, input int rv, input int ah, input int av);
        return {16'(app), 16'(rh), 16'(rv), 16'(ah), 16'(av)};
    endfunction

    function automatic logic [31:0] mk_spr(input bit vis, input bit hf, input int x, input int y);
        return {vis, hf, 10'(x), 10'(y), 10'd0};
    endfunction

    // Reference: plain integer arithmetic straight from the address rules.
    task automatic model(input logic [79:0] p, input logic [31:0] s, input logic [CNT_W-1:0] h,
                         input logic [CNT_W-1:0] v, output logic ev, output logic [ADDR_W-1:0] ea);
        int append, res_h, res_v, act_h, act_v, x, y, dx, dy, sx, sy;
        logic [31:0] col, sum;
        append = int'(p[79:64]); res_h = int'(p[63:48]); res_v = int'(p[47:32]);
        act_h  = int'(p[31:16]); act_v = int'(p[15:0]);
        x  = int'(s[29:20]); y = int'(s[19:10]);
        dx = int'(h) - x; if (dx < 0) dx += 2048;
        dy = int'(v) - y; if (dy < 0) dy += 2048;
        ev = s[31] && (dx < act_h) && (dy < act_v);
        sx = (act_h == 2 * res_h) ? dx / 2 : dx;
        sy = (act_v == 2 * res_v) ? dy / 2 : dy;
        col = 32'(sx);
        if (FLIP_ON && s[30]) col = 32'(res_h) - 32'd1 - 32'(sx);
        sum = 32'(append) + 32'(sy) * 32'(res_h) + col;
        ea = ev ? sum[ADDR_W-1:0] : '0;
    endtask

    task automatic check(input string name, input logic ev, input logic [ADDR_W-1:0] ea);
        total++;
        if (valid !== ev || addr_output !== ea) begin
            bad++;
            $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
                     name, valid, addr_output, ev, ea);
        end
    endtask

    task automatic drive(input logic [79:0] p, input logic [31:0] s, input logic [CNT_W-1:0] h,
                         input logic [CNT_W-1:0] v);
        pattern_info = p; sprite_info = s; hcount = h; vcount = v;
    endtask

    initial begin
        logic [79:0]       base_pat;
        logic [31:0]       base_spr;
        logic              ev;
        logic [ADDR_W-1:0] ea;
        total = 0;
        bad   = 0;

        base_pat = mk_pat(0, 64, 64, 64, 64);
        base_spr = mk_spr(1'b1, 1'b0, 100, 50);

        vecs.push_back('{"unscaled_hit", base_pat, base_spr, 10'd110, 10'd52, 1'b1, 16'd138});
        vecs.push_back('{"right_edge_in", base_pat, base_spr, 10'd163, 10'd52, 1'b1, 16'd191});
        vecs.push_back('{"right_edge_out", base_pat, base_spr, 10'd164, 10'd52, 1'b0, 16'd0});
        vecs.push_back('{"left_of_sprite", base_pat, base_spr, 10'd99, 10'd52, 1'b0, 16'd0});
        vecs.push_back('{"above_sprite", base_pat, base_spr, 10'd110, 10'd49, 1'b0, 16'd0});
        vecs.push_back('{"bottom_row", base_pat, base_spr, 10'd110, 10'd113, 1'b1, 16'd4042});
        vecs.push_back('{"below_sprite", base_pat, base_spr, 10'd110, 10'd114, 1'b0, 16'd0});
        vecs.push_back('{"hflip", base_pat, mk_spr(1'b1, 1'b1, 100, 50), 10'd110, 10'd52, 1'b1, FLIP_ADDR});
        vecs.push_back('{"scale_offset", mk_pat(512, 32, 32, 64, 64), mk_spr(1'b1, 1'b0, 0, 0),
                         10'd10, 10'd7, 1'b1, 16'd613});
        vecs.push_back('{"invisible", base_pat, mk_spr(1'b0, 1'b0, 100, 50), 10'd110, 10'd52, 1'b0, 16'd0});
        vecs.push_back('{"act_h_zero", mk_pat(0, 64, 64, 0, 64), base_spr, 10'd100, 10'd52, 1'b0, 16'd0});
        vecs.push_back('{"act_v_zero", mk_pat(0, 64, 64, 64, 0), base_spr, 10'd110, 10'd50, 1'b0, 16'd0});
        vecs.push_back('{"addr_wrap", mk_pat(16'hFFF0, 64, 64, 64, 64), base_spr, 10'd110, 10'd52,
                         1'b1, 16'd122});

        // Asynchronous reset with hit-producing inputs, before any clock edge.
        reset_n = 1'b0;
        drive(base_pat, base_spr, 10'd110, 10'd52);
        #2;
        check("reset_no_clk", 1'b0, 16'd0);
        @(posedge clk); #1;
        check("reset_held_edge", 1'b0, 16'd0);

        // Release between edges: output must wait for the next rising edge.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_release_pre_edge", 1'b0, 16'd0);
        @(posedge clk); #1;
        check("first_after_release", 1'b1, 16'd138);

        foreach (vecs[i]) begin
            drive(vecs[i].pat, vecs[i].spr, vecs[i].h, vecs[i].v);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_addr);
        end

        // Latency check: new inputs must not show before the edge.
        drive(base_pat, base_spr, 10'd110, 10'd52);
        @(posedge clk); #1;
        drive(base_pat, base_spr, 10'd164, 10'd52);
        #2;
        check("hold_until_edge", 1'b1, 16'd138);
        @(posedge clk); #1;
        check("update_on_edge", 1'b0, 16'd0);

        // Randomized, inputs changing every cycle.
        for (int n = 0; n < 600; n++) begin
            logic [79:0] p;
            logic [31:0] s;
            int rh, rv, ah, av, x, y, h, v;
            rh = $urandom_range(1, 80);
            rv = $urandom_range(1, 80);
            ah = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 200) : 2 * rh;
            av = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 200) : 2 * rv;
            if ($urandom_range(0, 3) == 0) begin ah = rh; av = rv; end
            if ($urandom_range(0, 15) == 0) ah = $urandom_range(0, 65535);
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            h = (x + int'($urandom_range(0, 220)) - 10) & 1023;
            v = (y + int'($urandom_range(0, 220)) - 10) & 1023;
            p = mk_pat(int'($urandom_range(0, 65535)), rh, rv, ah, av);
            s = mk_spr($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), x, y);
            s[9:0] = 10'($urandom_range(0, 1023));
            drive(p, s, 10'(h), 10'(v));
            model(p, s, 10'(h), 10'(v), ev, ea);
            @(posedge clk); #1;
            check($sformatf("random_%0d", n), ev, ea);
        end

        // Reset asserted mid-frame clears immediately.
        drive(base_pat, base_spr, 10'd110, 10'd52);
        @(posedge clk); #1;
        check("pre_midframe_reset", 1'b1, 16'd138);
        #2;
        reset_n = 1'b0;
        #1;
        check("midframe_reset", 1'b0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("recover_after_reset", 1'b1, 16'd138);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
